// File: rtl/serv_dbg_pkg.sv
// Shared types for the debug-mode sequencer: FSM state encoding and dcsr.cause values.
// SERV_DBG_STEP_EN adds the STEP state (and therefore a third state bit).
package serv_dbg_pkg;

  localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
  localparam logic [2:0] CAUSE_HALTREQ = 3'd3;
  localparam logic [2:0] CAUSE_STEP    = 3'd4;

`ifdef SERV_DBG_STEP_EN
  typedef enum logic [2:0] {
    RUN    = 3'd0,
    HALTED = 3'd1,
    RESUME = 3'd2,
    RESET  = 3'd3,
    STEP   = 3'd4
  } dbg_state_e;
`else
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    RESUME = 2'd2,
    RESET  = 2'd3
  } dbg_state_e;
`endif

endpackage

// File: rtl/serv_dbg_cause_enc.sv
// Priority encoder for debug-entry sources: step > ebreak > haltreq.
module serv_dbg_cause_enc (
  input  logic       i_step,
  input  logic       i_ebreak,
  input  logic       i_haltreq,
  output logic       o_valid,
  output logic [2:0] o_cause
);
  import serv_dbg_pkg::*;

  always_comb begin
    o_valid = 1'b1;
    o_cause = 3'd0;
    if (i_step)         o_cause = CAUSE_STEP;
    else if (i_ebreak)  o_cause = CAUSE_EBREAK;
    else if (i_haltreq) o_cause = CAUSE_HALTREQ;
    else                o_valid = 1'b0;
  end

endmodule

// File: rtl/serv_dbg_ctrl.sv
// Debug-mode sequencer: halt/resume/step/ndmreset handling at instruction boundaries.
// Define SERV_DBG_STEP_EN to build the single-step (STEP state, cause 4) support.
module serv_dbg_ctrl #(
  parameter bit STALL_ON_RESET = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_haltreq,
  input  logic       i_resumereq,
  input  logic       i_ndmreset,
  input  logic       i_init,
  input  logic       i_cnt_done,
  input  logic       i_ebreak,
  input  logic       i_ebreakm,
  input  logic       i_dret,
  input  logic       i_dbg_step,
  output logic       o_dbg_halt,
  output logic       o_dbg_reset,
  output logic       o_stall,
  output logic       o_halted,
  output logic       o_resumeack,
  output logic       o_dpc_wen,
  output logic [2:0] o_cause
);
  import serv_dbg_pkg::*;

  dbg_state_e r_state;
  logic       r_stall, r_halted, r_ack, r_dpc_wen, r_dbg_reset, r_dbg_halt;
  logic       r_ndm_q, r_rst_tail;
  logic [2:0] r_cause;

  logic       w_bnd, w_ndm_rise, w_in_step, w_enc_valid, w_enter;
  logic [2:0] w_enc_cause, w_enter_cause;
  dbg_state_e w_resume_tgt;

  assign w_bnd      = i_cnt_done & ~i_init;
  assign w_ndm_rise = i_ndmreset & ~r_ndm_q;

`ifdef SERV_DBG_STEP_EN
  assign w_in_step    = (r_state == STEP);
  assign w_resume_tgt = i_dbg_step ? STEP : RUN;
`else
  logic w_unused_step;
  assign w_unused_step = i_dbg_step;
  assign w_in_step     = 1'b0;
  assign w_resume_tgt  = RUN;
`endif

  // A pending haltreq must not steal the cause from an in-flight step.
  serv_dbg_cause_enc u_cause_enc (
    .i_step    (w_in_step),
    .i_ebreak  (i_ebreak & i_ebreakm),
    .i_haltreq (i_haltreq & ~w_in_step),
    .o_valid   (w_enc_valid),
    .o_cause   (w_enc_cause)
  );

  always_comb begin
    w_enter       = 1'b0;
    w_enter_cause = w_enc_cause;
    case (r_state)
      RUN:   w_enter = w_bnd & ~i_dret & w_enc_valid;
`ifdef SERV_DBG_STEP_EN
      STEP:  w_enter = w_bnd & ~i_dret;
`endif
      RESET: begin
        w_enter       = r_rst_tail & ~i_ndmreset & i_haltreq;
        w_enter_cause = CAUSE_HALTREQ;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= STALL_ON_RESET ? HALTED : RUN;
      r_stall     <= STALL_ON_RESET;
      r_halted    <= STALL_ON_RESET;
      r_cause     <= STALL_ON_RESET ? CAUSE_HALTREQ : 3'd0;
      r_ack       <= 1'b0;
      r_dpc_wen   <= 1'b0;
      r_dbg_reset <= 1'b0;
      r_dbg_halt  <= 1'b0;
      r_ndm_q     <= 1'b0;
      r_rst_tail  <= 1'b0;
    end else begin
      r_ndm_q    <= i_ndmreset;
      r_dpc_wen  <= w_enter & ~w_ndm_rise;
      r_dbg_halt <= w_enter & ~w_ndm_rise & (w_enter_cause == CAUSE_HALTREQ);
      if (!i_resumereq) r_ack <= 1'b0;

      if (w_ndm_rise) begin
        r_state     <= RESET;
        r_dbg_reset <= 1'b1;
        r_rst_tail  <= 1'b0;
        r_stall     <= 1'b0;
        r_halted    <= 1'b0;
      end else if (w_enter) begin
        r_state     <= HALTED;
        r_stall     <= 1'b1;
        r_halted    <= 1'b1;
        r_cause     <= w_enter_cause;
        r_dbg_reset <= 1'b0;
        r_rst_tail  <= 1'b0;
      end else begin
        case (r_state)
          HALTED: if (i_resumereq) begin
            r_state  <= RESUME;
            r_stall  <= 1'b0;
            r_halted <= 1'b0;
            r_ack    <= 1'b1;
          end
          RESUME: r_state <= w_resume_tgt;
          // Reset is held one extra cycle after ndmreset drops.
          RESET: if (!i_ndmreset) begin
            if (r_rst_tail) begin
              r_state     <= RUN;
              r_dbg_reset <= 1'b0;
              r_rst_tail  <= 1'b0;
            end else begin
              r_rst_tail  <= 1'b1;
            end
          end
          default: if (w_bnd && i_dret) r_state <= RUN;
        endcase
      end
    end
  end

  assign o_dbg_halt  = r_dbg_halt;
  assign o_dbg_reset = r_dbg_reset;
  assign o_stall     = r_stall;
  assign o_halted    = r_halted;
  assign o_resumeack = r_ack;
  assign o_dpc_wen   = r_dpc_wen;
  assign o_cause     = r_cause;

endmodule

// File: tb/tb_serv_dbg_ctrl.sv
// Scoreboard bench for serv_dbg_ctrl; expectations adapt to SERV_DBG_STEP_EN.
module tb_serv_dbg_ctrl;

  logic       i_clk, i_rst;
  logic       i_haltreq, i_resumereq, i_ndmreset, i_init, i_cnt_done;
  logic       i_ebreak, i_ebreakm, i_dret, i_dbg_step;
  logic       o_dbg_halt, o_dbg_reset, o_stall, o_halted, o_resumeack, o_dpc_wen;
  logic [2:0] o_cause;
  logic [8:0] w_obs;

  int n_chk = 0;
  int n_err = 0;

`ifdef SERV_DBG_STEP_EN
  localparam logic [2:0] STEP_C  = 3'd4;
  localparam bit         STEP_DH = 1'b0;
`else
  localparam logic [2:0] STEP_C  = 3'd3;
  localparam bit         STEP_DH = 1'b1;
`endif

  typedef struct {
    string      tag;
    logic [8:0] exp;
  } exp_t;
  exp_t sb_q[$];

  serv_dbg_ctrl #(.STALL_ON_RESET(1'b0)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_haltreq   (i_haltreq),
    .i_resumereq (i_resumereq),
    .i_ndmreset  (i_ndmreset),
    .i_init      (i_init),
    .i_cnt_done  (i_cnt_done),
    .i_ebreak    (i_ebreak),
    .i_ebreakm   (i_ebreakm),
    .i_dret      (i_dret),
    .i_dbg_step  (i_dbg_step),
    .o_dbg_halt  (o_dbg_halt),
    .o_dbg_reset (o_dbg_reset),
    .o_stall     (o_stall),
    .o_halted    (o_halted),
    .o_resumeack (o_resumeack),
    .o_dpc_wen   (o_dpc_wen),
    .o_cause     (o_cause)
  );

  // Observed vector: {halted, stall, resumeack, dpc_wen, dbg_reset, dbg_halt, cause}
  assign w_obs = {o_halted, o_stall, o_resumeack, o_dpc_wen, o_dbg_reset, o_dbg_halt, o_cause};

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  function automatic logic [8:0] ex(input bit h, input bit s, input bit a, input bit d,
                                    input bit r, input bit dh, input logic [2:0] c);
    return {h, s, a, d, r, dh, c};
  endfunction

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got h,s,ack,dpc,rst,dh,cause=%b required %b", tag, obs, exp);
    end
  endtask

  // Push the expectation for the coming edge, then compare once the DUT has updated.
  task automatic cyc(input string tag, input logic [8:0] exp);
    exp_t e;
    sb_q.push_back('{tag, exp});
    @(posedge i_clk);
    #1;
    e = sb_q.pop_front();
    check(e.tag, w_obs, e.exp);
  endtask

  task automatic expect_now(input string tag, input logic [8:0] exp);
    exp_t e;
    sb_q.push_back('{tag, exp});
    e = sb_q.pop_front();
    check(e.tag, w_obs, e.exp);
  endtask

  initial begin
    i_rst = 1'b1;
    i_haltreq = 1'b0; i_resumereq = 1'b0; i_ndmreset = 1'b0; i_init = 1'b0;
    i_cnt_done = 1'b0; i_ebreak = 1'b0; i_ebreakm = 1'b0; i_dret = 1'b0; i_dbg_step = 1'b0;
    #2;
    expect_now("reset_vals", ex(0,0,0,0,0,0,3'd0));
    #10;
    i_rst = 1'b0;

    // haltreq held; only a real boundary (cnt_done & !init) may halt
    i_haltreq = 1'b1;
    for (int i = 0; i < 8; i++) cyc($sformatf("hreq_nobnd%0d", i), ex(0,0,0,0,0,0,3'd0));
    i_cnt_done = 1'b1; i_init = 1'b1;
    cyc("hreq_init_bnd", ex(0,0,0,0,0,0,3'd0));
    i_init = 1'b0;
    cyc("hreq_entry", ex(1,1,0,1,0,1,3'd3));
    i_cnt_done = 1'b0; i_haltreq = 1'b0;
    cyc("hreq_halted", ex(1,1,0,0,0,0,3'd3));

    // resume held five cycles; ack follows the request level
    i_resumereq = 1'b1;
    for (int i = 0; i < 5; i++) cyc($sformatf("resume_ack%0d", i), ex(0,0,1,0,0,0,3'd3));
    i_resumereq = 1'b0;
    cyc("resume_ack_drop", ex(0,0,0,0,0,0,3'd3));
    i_resumereq = 1'b1;
    for (int i = 0; i < 2; i++) cyc($sformatf("resume_in_run%0d", i), ex(0,0,0,0,0,0,3'd3));
    i_resumereq = 1'b0;

    // ebreak vs haltreq priority, gated by ebreakm
    i_ebreak = 1'b1; i_haltreq = 1'b1; i_ebreakm = 1'b1; i_cnt_done = 1'b1;
    cyc("ebrk_entry", ex(1,1,0,1,0,0,3'd1));
    i_ebreak = 1'b0; i_haltreq = 1'b0; i_cnt_done = 1'b0;
    cyc("ebrk_halted", ex(1,1,0,0,0,0,3'd1));
    i_resumereq = 1'b1;
    cyc("ebrk_resume", ex(0,0,1,0,0,0,3'd1));
    i_resumereq = 1'b0;
    cyc("ebrk_run", ex(0,0,0,0,0,0,3'd1));
    i_ebreak = 1'b1; i_haltreq = 1'b1; i_ebreakm = 1'b0; i_cnt_done = 1'b1;
    cyc("ebrk_m0_entry", ex(1,1,0,1,0,1,3'd3));
    i_ebreak = 1'b0; i_haltreq = 1'b0; i_cnt_done = 1'b0;
    cyc("ebrk_m0_halted", ex(1,1,0,0,0,0,3'd3));

    // single step with a concurrent haltreq
    i_dbg_step = 1'b1; i_resumereq = 1'b1;
    cyc("step_resume", ex(0,0,1,0,0,0,3'd3));
    i_resumereq = 1'b0;
    cyc("step_run", ex(0,0,0,0,0,0,3'd3));
    i_haltreq = 1'b1;
    cyc("step_nobnd", ex(0,0,0,0,0,0,3'd3));
    i_cnt_done = 1'b1;
    cyc("step_entry", ex(1,1,0,1,0,STEP_DH,STEP_C));
    i_cnt_done = 1'b0; i_haltreq = 1'b0;
    cyc("step_halted", ex(1,1,0,0,0,0,STEP_C));

    // dret at the boundary of a stepped instruction returns to RUN
    i_resumereq = 1'b1;
    cyc("dret_resume", ex(0,0,1,0,0,0,STEP_C));
    i_resumereq = 1'b0;
    cyc("dret_run", ex(0,0,0,0,0,0,STEP_C));
    i_dret = 1'b1; i_cnt_done = 1'b1;
    cyc("dret_bnd", ex(0,0,0,0,0,0,STEP_C));
    i_dret = 1'b0; i_dbg_step = 1'b0;
    cyc("dret_next_bnd", ex(0,0,0,0,0,0,STEP_C));
    i_cnt_done = 1'b0;

    // ndmreset for 3 cycles with haltreq -> 4 reset cycles, then halt
    i_haltreq = 1'b1; i_ndmreset = 1'b1;
    for (int i = 0; i < 3; i++) cyc($sformatf("ndm_rst%0d", i), ex(0,0,0,0,1,0,STEP_C));
    i_ndmreset = 1'b0;
    cyc("ndm_rst_tail", ex(0,0,0,0,1,0,STEP_C));
    cyc("ndm_halt_entry", ex(1,1,0,1,0,1,3'd3));
    i_haltreq = 1'b0;
    cyc("ndm_halted", ex(1,1,0,0,0,0,3'd3));

    // ndmreset without haltreq -> back to RUN
    i_ndmreset = 1'b1;
    cyc("ndm2_rst", ex(0,0,0,0,1,0,3'd3));
    i_ndmreset = 1'b0;
    cyc("ndm2_tail", ex(0,0,0,0,1,0,3'd3));
    cyc("ndm2_run", ex(0,0,0,0,0,0,3'd3));

    // async reset in the middle of a step
    i_haltreq = 1'b1; i_cnt_done = 1'b1;
    cyc("arst_entry", ex(1,1,0,1,0,1,3'd3));
    i_haltreq = 1'b0; i_cnt_done = 1'b0;
    cyc("arst_halted", ex(1,1,0,0,0,0,3'd3));
    i_dbg_step = 1'b1; i_resumereq = 1'b1;
    cyc("arst_resume", ex(0,0,1,0,0,0,3'd3));
    i_resumereq = 1'b0;
    cyc("arst_step", ex(0,0,0,0,0,0,3'd3));
    #2;
    i_rst = 1'b1;
    #1;
    expect_now("arst_immediate", ex(0,0,0,0,0,0,3'd0));
    #2;
    i_rst = 1'b0;
    i_cnt_done = 1'b1; i_dbg_step = 1'b0;
    cyc("arst_back_in_run", ex(0,0,0,0,0,0,3'd0));
    i_cnt_done = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/serv_dbg_ctrl.md
# serv_dbg_ctrl

Debug-mode sequencer for the bit-serial core. It accepts halt, resume and reset requests from the Debug Module and decides, at instruction boundaries only, when the core enters or leaves debug mode. It drives the halt/reset/cause qualifiers consumed by the CSR unit, and it stalls instruction fetch while halted. It owns the single-step sequence that is armed by dcsr.step.

## Interface
- `STALL_ON_RESET`, default 0: when 1, the block comes out of reset in HALTED with cause=haltreq.
- `i_clk`  in  1  core clock.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_haltreq`  in  1  DM halt request, level.
- `i_resumereq`  in  1  DM resume request, level.
- `i_ndmreset`  in  1  DM non-debug-module reset request, level.
- `i_init`  in  1  core is in the init phase of an instruction.
- `i_cnt_done`  in  1  last serial cycle of the current phase.
- `i_ebreak`  in  1  current instruction is ebreak.
- `i_ebreakm`  in  1  dcsr.ebreakm; ebreak enters debug mode instead of trapping.
- `i_dret`  in  1  current instruction is dret.
- `i_dbg_step`  in  1  dcsr.step from the CSR unit.
- `o_dbg_halt`  out  1  debug entry requested by the DM (CSR cause qualifier).
- `o_dbg_reset`  out  1  core/CSR reset pulse.
- `o_stall`  out  1  freeze fetch/issue.
- `o_halted`  out  1  hart halted (DM status).
- `o_resumeack`  out  1  resume acknowledged (DM status).
- `o_dpc_wen`  out  1  capture the PC into dpc.
- `o_cause`  out  3  dcsr.cause.

## Operation
- Boundary event `bnd` = `i_cnt_done & !i_init`. Debug entry and exit happen only at `bnd` or while the core is stalled.
- States:
  - RUN: normal execution.
  - HALTED: `o_stall` = 1, `o_halted` = 1.
  - RESUME: single cycle. Releases the stall and sets `o_resumeack`.
  - STEP: executes exactly one instruction, then re-halts.
  - RESET: holds `o_dbg_reset`.
- Entry sources and `o_cause` encodings:
  - step = 4 (STEP state reaches `bnd`).
  - ebreak = 1 (`bnd & i_ebreak & i_ebreakm`).
  - haltreq = 3 (`bnd & i_haltreq`).
  - Priority when simultaneous: step > ebreak > haltreq.
- On entry:
  - State becomes HALTED and `o_cause` latches the winning source.
  - `o_dpc_wen` pulses for one cycle.
  - `o_dbg_halt` = 1 only when cause=3.
- HALTED with `i_resumereq`:
  - Go to RESUME; `o_resumeack` becomes 1 and stays 1 until `i_resumereq` falls.
  - RESUME -> STEP if `i_dbg_step`, else -> RUN.
- `i_dret` at `bnd` in RUN or STEP is treated as a resume:
  - Go to RUN.
  - No `o_resumeack` change, no `o_dpc_wen`.
- In STEP, `i_haltreq` is ignored; the step completes with cause=4.
- `i_ndmreset` rising edge from any state:
  - Enter RESET; `o_dbg_reset` = 1 for as long as `i_ndmreset` is high, plus 1 cycle.
  - Then go to HALTED if `i_haltreq` is set, else RUN.
  - `o_cause` = 3 in the HALTED case.
- A resume request arriving in RUN is ignored.

## Timing
- All outputs are registered.
- Reset values:
  - state = RUN (HALTED if `STALL_ON_RESET`).
  - `o_stall` = `o_halted` = `STALL_ON_RESET`.
  - `o_resumeack` = 0, `o_dpc_wen` = 0, `o_dbg_reset` = 0, `o_dbg_halt` = 0.
  - `o_cause` = 0 (3 if `STALL_ON_RESET`).
- Entry latency: `o_halted`, `o_stall` and `o_dpc_wen` are high in the cycle after the qualifying `bnd`.
- Resume latency:
  - `o_resumeack` rises and `o_stall` falls 1 cycle after `i_resumereq` is sampled in HALTED.
  - `o_halted` falls on the same edge.
- Step: re-halt 1 cycle after the first `bnd` following RESUME.
- `i_rst` mid-sequence aborts to reset values immediately (asynchronous).

## Configuration
- `SERV_DBG_STEP_EN` defined: STEP state and cause 4 are implemented.
- `SERV_DBG_STEP_EN` undefined:
  - `i_dbg_step` is ignored; RESUME always goes to RUN.
  - `o_cause` is never 4.
  - State encoding shrinks accordingly.

## Structure
- Package `serv_dbg_pkg` holds:
  - the state enum (RUN, HALTED, RESUME, STEP, RESET);
  - cause constants `CAUSE_EBREAK` = 1, `CAUSE_HALTREQ` = 3, `CAUSE_STEP` = 4.
- One sub-module, `serv_dbg_cause_enc`: combinational priority encoder from {step, ebreak, haltreq} to valid and cause[2:0].
- The FSM lives in the top level.

## Test plan
- `i_haltreq` held, `bnd` at cycle 10 -> at cycle 11: `o_halted` = 1, `o_stall` = 1, `o_cause` = 3, `o_dpc_wen` pulses once.
- In HALTED, `i_resumereq` = 1 for 5 cycles -> next cycle `o_resumeack` = 1 and `o_stall` = 0; `o_resumeack` drops the cycle after the request drops.
- With `i_dbg_step` = 1, resume -> one `bnd` later `o_halted` = 1, `o_cause` = 4; a concurrent `i_haltreq` still gives cause 4.
- `bnd` with `i_ebreak` = 1 and `i_haltreq` = 1, `i_ebreakm` = 1 -> cause 1; with `i_ebreakm` = 0 -> cause 3.
- `i_ndmreset` pulsed for 3 cycles while `i_haltreq` = 1 -> `o_dbg_reset` high for 4 cycles, then HALTED with cause 3.
- Assert `i_rst` while in STEP -> all outputs return to reset values immediately; build without `SERV_DBG_STEP_EN` -> step resume goes to RUN.
